pipeline_sequencer: RTL and testbench

Parametrised program-counter and pipeline-flush sequencer for the RV32E core's control path. Holds the architectural fetch PC, arbitrates several prioritised redirect sources (branch, jump, trap return), broadcasts flush and epoch to every pipeline stage and skid buffer, and adds drain, halt and misaligned-target trap behaviour. Sits between the fetch, decode and execute units and the fetch bus master.

---
 rtl/pipeline_sequencer_pkg.sv | 20 ++
 rtl/pipeline_sequencer_redirect_arbiter.sv | 33 +++
 rtl/pipeline_sequencer.sv | 119 +++++++++++
 tb/tb_pipeline_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the fetch PC / flush sequencer.
// Imported by the sequencer top and its redirect arbiter.
package pipeline_sequencer_pkg;

    localparam int          XLEN_DEFAULT         = 32;
    localparam int          PC_INCR              = 4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    function automatic logic pc_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_redirect_arbiter.sv
// Fixed-priority redirect arbiter: lowest-index request wins,
// losers are dropped; target is muxed by the one-hot grant.
module pipeline_sequencer_redirect_arbiter
    import pipeline_sequencer_pkg::*;
#(
    parameter int NUM_REDIRECTS = 2,
    parameter int XLEN          = XLEN_DEFAULT
) (
    input  logic [NUM_REDIRECTS-1:0]           i_valid,
    input  logic [NUM_REDIRECTS-1:0][XLEN-1:0] i_target,
    output logic                               o_any,
    output logic [XLEN-1:0]                    o_target
);

    logic [NUM_REDIRECTS-1:0] w_grant;

    // Isolate the lowest set request bit as a one-hot grant
    always_comb begin
        w_grant = i_valid & (~i_valid + NUM_REDIRECTS'(1));
        o_any   = |i_valid;
    end

    // AND-OR target mux driven by the one-hot grant
    always_comb begin
        o_target = '0;
        for (int i = 0; i < NUM_REDIRECTS; i++) begin
            if (w_grant[i]) begin
                o_target = o_target | i_target[i];
            end
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Fetch PC holder and pipeline flush / epoch / halt sequencer.
// Redirects win over halt and increment; misaligned targets trap.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int              XLEN          = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR  = RESET_VECTOR_DEFAULT,
    parameter logic [XLEN-1:0] TRAP_VECTOR   = TRAP_VECTOR_DEFAULT,
    parameter int              NUM_REDIRECTS = 2,
    parameter int              NUM_STAGES    = 3,
    parameter int              FLUSH_CYCLES  = 1,
    parameter int              EPOCH_WIDTH   = 2
) (
    input  logic                               clock,
    input  logic                               nreset,
    input  logic                               i_increment,
    input  logic [NUM_REDIRECTS-1:0]           i_redirect_valid,
    input  logic [NUM_REDIRECTS-1:0][XLEN-1:0] i_redirect_pc,
    input  logic                               i_halt_req,
    input  logic                               i_resume,
    output logic [XLEN-1:0]                    o_pc,
    output logic                               o_fetch_enable,
    output logic [NUM_STAGES-1:0]              o_flush,
    output logic [EPOCH_WIDTH-1:0]             o_epoch,
    output logic                               o_trap,
    output logic [XLEN-1:0]                    o_trap_pc,
    output logic                               o_halted
);

    // Counter holds the FLUSH-state cycles still to go after this one
    localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD =
        (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;

    seq_state_t             r_state;
    logic [CW-1:0]          r_count;
    logic [XLEN-1:0]        r_pc;
    logic [EPOCH_WIDTH-1:0] r_epoch;
    logic                   r_trap;
    logic [XLEN-1:0]        r_trap_pc;

    logic                   w_redirect_any;
    logic [XLEN-1:0]        w_target;

    pipeline_sequencer_redirect_arbiter #(
        .NUM_REDIRECTS (NUM_REDIRECTS),
        .XLEN          (XLEN)
    ) u_arbiter (
        .i_valid  (i_redirect_valid),
        .i_target (i_redirect_pc),
        .o_any    (w_redirect_any),
        .o_target (w_target)
    );

    // Sequencer FSM: PC, epoch, trap capture and flush/halt state
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state   <= ST_RUN;
            r_count   <= '0;
            r_pc      <= RESET_VECTOR;
            r_epoch   <= '0;
            r_trap    <= 1'b0;
            r_trap_pc <= '0;
        end else begin
            r_trap <= 1'b0;
            if (w_redirect_any) begin
                r_epoch <= r_epoch + EPOCH_WIDTH'(1);
                if (pc_aligned(w_target[1:0])) begin
                    r_pc <= w_target;
                end else begin
                    r_pc      <= TRAP_VECTOR;
                    r_trap_pc <= w_target;
                    r_trap    <= 1'b1;
                end
                if (r_state != ST_HALTED && FLUSH_CYCLES > 1) begin
                    r_state <= ST_FLUSH;
                    r_count <= CNT_LOAD;
                end
            end else begin
                unique case (r_state)
                    ST_RUN: begin
                        if (i_halt_req) begin
                            r_state <= ST_HALTED;
                        end else if (i_increment) begin
                            r_pc <= r_pc + XLEN'(PC_INCR);
                        end
                    end
                    ST_FLUSH: begin
                        if (r_count == '0) begin
                            r_state <= i_halt_req ? ST_HALTED : ST_RUN;
                        end else begin
                            r_count <= r_count - CW'(1);
                        end
                    end
                    ST_HALTED: begin
                        if (i_resume && !i_halt_req) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= ST_RUN;
                    end
                endcase
            end
        end
    end

    // Flush fans out combinationally so the redirect cycle is covered
    always_comb begin
        o_flush = {NUM_STAGES{w_redirect_any | (r_state == ST_FLUSH)}};
        o_fetch_enable = (r_state == ST_RUN) & ~w_redirect_any & ~i_halt_req;
        o_pc      = r_pc;
        o_epoch   = r_epoch;
        o_trap    = r_trap;
        o_trap_pc = r_trap_pc;
        o_halted  = (r_state == ST_HALTED);
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: two instances (FLUSH_CYCLES 1 and 3)
// share stimulus and are compared against a behavioural model.
module tb_pipeline_sequencer;

    localparam int NI = 2;
    localparam int FCS [NI] = '{1, 3};

    logic             clock;
    logic             nreset;
    logic             increment;
    logic [1:0]       rv;
    logic [1:0][31:0] rpc;
    logic             halt_req;
    logic             resume;

    logic [31:0] pc_o    [NI];
    logic        fe_o    [NI];
    logic [2:0]  flush_o [NI];
    logic [1:0]  ep_o    [NI];
    logic        trap_o  [NI];
    logic [31:0] tpc_o   [NI];
    logic        halt_o  [NI];

    pipeline_sequencer #(.FLUSH_CYCLES(1)) u_fc1 (
        .clock            (clock),
        .nreset           (nreset),
        .i_increment      (increment),
        .i_redirect_valid (rv),
        .i_redirect_pc    (rpc),
        .i_halt_req       (halt_req),
        .i_resume         (resume),
        .o_pc             (pc_o[0]),
        .o_fetch_enable   (fe_o[0]),
        .o_flush          (flush_o[0]),
        .o_epoch          (ep_o[0]),
        .o_trap           (trap_o[0]),
        .o_trap_pc        (tpc_o[0]),
        .o_halted         (halt_o[0])
    );

    pipeline_sequencer #(.FLUSH_CYCLES(3)) u_fc3 (
        .clock            (clock),
        .nreset           (nreset),
        .i_increment      (increment),
        .i_redirect_valid (rv),
        .i_redirect_pc    (rpc),
        .i_halt_req       (halt_req),
        .i_resume         (resume),
        .o_pc             (pc_o[1]),
        .o_fetch_enable   (fe_o[1]),
        .o_flush          (flush_o[1]),
        .o_epoch          (ep_o[1]),
        .o_trap           (trap_o[1]),
        .o_trap_pc        (tpc_o[1]),
        .o_halted         (halt_o[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: fl = further cycles flush stays high
    logic [31:0] m_pc   [NI];
    logic [31:0] m_tpc  [NI];
    int          m_ep   [NI];
    int          m_fl   [NI];
    bit          m_h    [NI];
    bit          m_trap [NI];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NI; k++) begin
            m_pc[k]   = 32'h0;
            m_tpc[k]  = 32'h0;
            m_ep[k]   = 0;
            m_fl[k]   = 0;
            m_h[k]    = 1'b0;
            m_trap[k] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        logic [31:0] tgt;
        for (int k = 0; k < NI; k++) begin
            if (rv != 2'b00) begin
                tgt = rv[0] ? rpc[0] : rpc[1];
                m_ep[k] = (m_ep[k] + 1) % 4;
                if (tgt % 4 == 0) begin
                    m_pc[k]   = tgt;
                    m_trap[k] = 1'b0;
                end else begin
                    m_pc[k]   = 32'h4;
                    m_tpc[k]  = tgt;
                    m_trap[k] = 1'b1;
                end
                if (!m_h[k]) m_fl[k] = FCS[k] - 1;
            end else begin
                m_trap[k] = 1'b0;
                if (m_h[k]) begin
                    if (resume && !halt_req) m_h[k] = 1'b0;
                end else if (m_fl[k] > 0) begin
                    m_fl[k]--;
                    if (m_fl[k] == 0 && halt_req) m_h[k] = 1'b1;
                end else if (halt_req) begin
                    m_h[k] = 1'b1;
                end else if (increment) begin
                    m_pc[k] = m_pc[k] + 32'd4;
                end
            end
        end
    endfunction

    task automatic check_all();
        bit f;
        bit fe;
        string p;
        for (int k = 0; k < NI; k++) begin
            p  = $sformatf("fc%0d.", FCS[k]);
            f  = (rv != 2'b00) || (m_fl[k] > 0);
            fe = !m_h[k] && m_fl[k] == 0 && rv == 2'b00 && !halt_req;
            check({p, "pc"},      pc_o[k],           m_pc[k]);
            check({p, "epoch"},   32'(ep_o[k]),      32'(m_ep[k]));
            check({p, "flush"},   32'(flush_o[k]),   f ? 32'h7 : 32'h0);
            check({p, "fe"},      32'(fe_o[k]),      32'(fe));
            check({p, "trap"},    32'(trap_o[k]),    32'(m_trap[k]));
            check({p, "trap_pc"}, tpc_o[k],          m_tpc[k]);
            check({p, "halted"},  32'(halt_o[k]),    32'(m_h[k]));
        end
    endtask

    task automatic cycle(input bit inc, input bit [1:0] v,
                         input logic [31:0] t0, input logic [31:0] t1,
                         input bit hr, input bit rs);
        @(negedge clock);
        increment = inc;
        rv        = v;
        rpc[0]    = t0;
        rpc[1]    = t1;
        halt_req  = hr;
        resume    = rs;
        #1;
        check_all();
        @(posedge clock);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clock);
        increment = 1'b0;
        rv        = 2'b00;
        halt_req  = 1'b0;
        resume    = 1'b0;
        #2;
        nreset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clock);
        nreset = 1'b1;
    endtask

    initial begin
        bit hr;
        bit [1:0] v;
        logic [31:0] t0;
        logic [31:0] t1;
        nreset    = 1'b0;
        increment = 1'b0;
        rv        = 2'b00;
        rpc       = '0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        model_reset();
        #12;
        check_all();
        nreset = 1'b1;

        // sequential fetch
        repeat (3) cycle(1, 2'b00, 0, 0, 0, 0);
        #1 check("pc12", pc_o[0], 32'd12);

        // two channels: ch0 wins, increment ignored
        cycle(1, 2'b11, 32'h40, 32'h80, 0, 0);
        #1 check("pc40", pc_o[0], 32'h40);
        check("ep1", 32'(ep_o[1]), 32'd1);

        // long flush on the 3-cycle instance
        cycle(1, 2'b01, 32'h100, 32'h0, 0, 0);
        repeat (3) cycle(1, 2'b00, 0, 0, 0, 0);
        #1 check("fc3.pc104", pc_o[1], 32'h104);

        // misaligned target traps
        cycle(0, 2'b10, 32'h0, 32'h102, 0, 0);
        #1 check("trap_pc", tpc_o[0], 32'h102);
        check("trap_vec", pc_o[0], 32'h4);
        check("trap_hi", 32'(trap_o[0]), 32'd1);
        cycle(0, 2'b00, 0, 0, 0, 0);
        #1 check("trap_lo", 32'(trap_o[0]), 32'd0);

        // halt, redirect while halted, resume
        repeat (3) cycle(0, 2'b00, 0, 0, 1, 0);
        cycle(0, 2'b01, 32'h200, 32'h0, 1, 0);
        #1 check("halt_pc", pc_o[1], 32'h200);
        check("still_halted", 32'(halt_o[1]), 32'd1);
        cycle(0, 2'b00, 0, 0, 1, 1);
        cycle(0, 2'b00, 0, 0, 0, 1);
        cycle(1, 2'b00, 0, 0, 0, 0);
        #1 check("pc204", pc_o[1], 32'h204);

        // epoch wrap, then reset in the middle of a flush
        for (int i = 0; i < 4; i++)
            cycle(0, 2'b01, 32'h300 + 32'(i * 16), 32'h0, 0, 0);
        cycle(0, 2'b00, 0, 0, 0, 0);
        do_reset();

        // randomized traffic
        hr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 24) == 0) hr = !hr;
            v  = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            t0 = $urandom & 32'hFFFF_FFFC;
            t1 = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) t0[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) t1[1:0] = 2'($urandom_range(1, 3));
            cycle($urandom_range(0, 3) != 0, v, t0, t1, hr,
                  $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
